esp_dma_responder: RTL and testbench
====================================

ESP_DMA_RESPONDER -- requirements
Module: esp_dma_responder

Interface
REQ-001 Parameter ADDR_W, default 16: memory depth 2^ADDR_W words of 64 bits.
REQ-002 Parameter MAX_LEN, default 32768: largest accepted burst length, in beats.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 dma_read_ctrl_valid/ready  in/out  1/1  read-request handshake.
REQ-006 dma_read_ctrl_data_index/length  in  32/32  read start word and beat count.
REQ-007 dma_read_ctrl_data_size/user  in  3/5  transfer size and user tag; user is ignored.
REQ-008 dma_read_chnl_valid/ready  out/in  1/1  read-data handshake; dma_read_chnl_data  out  64.
REQ-009 dma_write_ctrl_valid/ready, dma_write_ctrl_data_index/length/size/user  as REQ-005..007, for writes.
REQ-010 dma_write_chnl_valid/ready  in/out  1/1  write-data handshake; dma_write_chnl_data  in  64.
REQ-011 host_we  in  1, host_waddr  in  ADDR_W, host_wdata  in  64: host preload port.
REQ-012 host_raddr  in  ADDR_W, host_rdata  out  64: host readback port, registered.
REQ-013 busy  out  1: high when not IDLE; size_err, oob_err  out  1/1: sticky error flags.
REQ-014 rd_bursts, wr_bursts  out  16/16: completed-burst counters.

Function
REQ-015 Memory is true dual-port: port A serves the DMA path, port B serves the host path; both ports read synchronously with 1-cycle latency.
REQ-016 FSM states: IDLE, RD_FETCH, RD_STREAM, WR_STREAM.
REQ-017 In IDLE, dma_read_ctrl_ready=1 and dma_write_ctrl_ready=!dma_read_ctrl_valid; read has priority when both requests are valid in the same cycle.
REQ-018 Outside IDLE, both ctrl_ready outputs are 0.
REQ-019 Handshake: a transfer occurs in a cycle where valid && ready are both high.
REQ-020 On a ctrl handshake, latch addr=index[ADDR_W-1:0] and beats=length, then go to RD_FETCH (read) or WR_STREAM (write).
REQ-021 A request with length=0 completes immediately: the FSM returns to IDLE the next cycle, transfers no beats, and still increments the matching burst counter.
REQ-022 length>MAX_LEN: set oob_err and clamp beats to MAX_LEN.
REQ-023 If index+length exceeds 2^ADDR_W, set oob_err; addresses wrap modulo 2^ADDR_W.
REQ-024 size!=3'b011 sets size_err; the transfer is still processed as 64-bit beats.
REQ-025 RD_FETCH lasts 1 cycle (RAM latency).
REQ-026 dma_read_chnl_valid rises the second cycle after the ctrl handshake.
REQ-027 A 2-entry output buffer sustains 1 beat/cycle while dma_read_chnl_ready=1.
REQ-028 Under backpressure (valid=1, ready=0), dma_read_chnl_data holds stable and valid stays 1.
REQ-029 No read is issued that would overflow the 2-entry output buffer.
REQ-030 Beat k of a read burst returns mem[(addr+k) mod 2^ADDR_W], in order, exactly beats words.
REQ-031 After the last read beat handshake: go to IDLE, increment rd_bursts, and deassert dma_read_chnl_valid the next cycle.
REQ-032 WR_STREAM: dma_write_chnl_ready=1; each accepted beat k writes mem[(addr+k) mod 2^ADDR_W].
REQ-033 After the last accepted write beat: go to IDLE and increment wr_bursts.
REQ-034 host_rdata = mem[host_raddr] from the previous cycle.
REQ-035 host_we writes in any state.
REQ-036 If a DMA write and a host write hit the same address in the same cycle, the DMA data is stored.
REQ-037 Burst counters wrap from 0xFFFF to 0.
REQ-038 Write-then-read of the same address in back-to-back bursts returns the new data.

Reset
REQ-039 When rst_n=0, asynchronously: FSM=IDLE, and all chnl_valid, ctrl_ready and busy outputs are 0.
REQ-040 When rst_n=0, asynchronously: size_err=0, oob_err=0, rd_bursts=0, wr_bursts=0, host_rdata=0, and the output buffer is emptied.
REQ-041 Memory contents are not reset.
REQ-042 Reset mid-burst discards the remaining beats; the first cycle after release is IDLE with ctrl_ready per REQ-017.

Verification
REQ-043 Host preloads mem[0..255] = i; read index=0, length=64, ready held 1 -> 64 beats of values 0..63, one beat per cycle, valid rises at handshake+2, then rd_bursts=1.
REQ-044 Read index=10, length=8 with ready toggled randomly -> values 10..17 in order; data stays stable under every ready=0; no beat is lost or duplicated.
REQ-045 Write index=100, length=16 with data 0xA5A5_0000_0000_0000+k, then read the same range -> identical data, wr_bursts=1.
REQ-046 Read and write requests valid in the same IDLE cycle -> read accepted first; write accepted after the read burst ends.
REQ-047 Read index=2^ADDR_W-2, length=4 -> mem[last-1], mem[last], mem[0], mem[1] returned and oob_err=1; a separate request with size=3'b010 -> size_err=1.
REQ-048 length=0 request -> no chnl_valid, IDLE next cycle; rst_n pulsed mid-read at beat 5 of 32 -> all outputs at reset values and the next request is served normally.

Source files
------------

// File: rtl/esp_dma_responder.sv
`default_nettype none
// ============================================================================
//  Module   : esp_dma_responder
//  Purpose  : DMA target backed by a 2^ADDR_W x 64-bit true dual-port RAM.
//             Port A serves read/write DMA bursts, port B serves a host
//             preload/readback path. Read data is streamed through a 2-entry
//             output buffer so one beat per cycle is sustained.
//  Ports    : clk, rst_n (async, active-low)
//             dma_read_ctrl_*  / dma_read_chnl_*  : read request + read data
//             dma_write_ctrl_* / dma_write_chnl_* : write request + write data
//             host_we/waddr/wdata, host_raddr/rdata : host RAM port
//             busy, size_err, oob_err, rd_bursts, wr_bursts : status
//  Revision : 1.0 - initial release
// ============================================================================
module esp_dma_responder #(
    parameter int ADDR_W  = 16,
    parameter int MAX_LEN = 32768
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dma_read_ctrl_valid,
    output logic              dma_read_ctrl_ready,
    input  logic [31:0]       dma_read_ctrl_data_index,
    input  logic [31:0]       dma_read_ctrl_data_length,
    input  logic [2:0]        dma_read_ctrl_data_size,
    input  logic [4:0]        dma_read_ctrl_data_user,
    output logic              dma_read_chnl_valid,
    input  logic              dma_read_chnl_ready,
    output logic [63:0]       dma_read_chnl_data,
    input  logic              dma_write_ctrl_valid,
    output logic              dma_write_ctrl_ready,
    input  logic [31:0]       dma_write_ctrl_data_index,
    input  logic [31:0]       dma_write_ctrl_data_length,
    input  logic [2:0]        dma_write_ctrl_data_size,
    input  logic [4:0]        dma_write_ctrl_data_user,
    input  logic              dma_write_chnl_valid,
    output logic              dma_write_chnl_ready,
    input  logic [63:0]       dma_write_chnl_data,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_waddr,
    input  logic [63:0]       host_wdata,
    input  logic [ADDR_W-1:0] host_raddr,
    output logic [63:0]       host_rdata,
    output logic              busy,
    output logic              size_err,
    output logic              oob_err,
    output logic [15:0]       rd_bursts,
    output logic [15:0]       wr_bursts
);

    localparam int                c_DEPTH     = 1 << ADDR_W;
    localparam int                c_LEN_W     = $clog2(MAX_LEN + 1);
    localparam logic [31:0]       c_MAX_LEN   = 32'(MAX_LEN);
    localparam logic [32:0]       c_MEM_WORDS = 33'd1 << ADDR_W;
    localparam logic [c_LEN_W-1:0] c_ONE      = c_LEN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RD_FETCH  = 2'd1,
        S_RD_STREAM = 2'd2,
        S_WR_STREAM = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [ADDR_W-1:0]    r_addr;      // next RAM word to read or write
    logic [c_LEN_W-1:0]   r_left;      // reads still to issue / writes still to accept
    logic [c_LEN_W-1:0]   r_out_left;  // read beats still to hand over
    logic                 r_rd_pend;   // RAM read issued last cycle, data in r_a_q
    logic [63:0]          r_a_q;
    logic [63:0]          r_mem [0:c_DEPTH-1];
    logic [63:0]          r_buf [0:1];
    logic                 r_wptr;
    logic                 r_rptr;
    logic [1:0]           r_cnt;

    logic                 w_rd_hs;
    logic                 w_wr_hs;
    logic                 w_hs;
    logic [31:0]          w_req_index;
    logic [31:0]          w_req_length;
    logic [2:0]           w_req_size;
    logic                 w_len_over;
    logic [c_LEN_W-1:0]   w_req_beats;
    logic                 w_req_zero;
    logic [32:0]          w_req_end;
    logic                 w_req_oob;
    logic                 w_pop;
    logic [2:0]           w_occ;
    logic                 w_room;
    logic                 w_rd_issue;
    logic                 w_wr_accept;
    logic [ADDR_W-1:0]    w_a_addr;
    logic                 w_unused_ok;

    assign w_unused_ok = ^{dma_read_ctrl_data_user, dma_write_ctrl_data_user};

    // ctrl readies are forced low while reset is asserted
    assign dma_read_ctrl_ready  = rst_n & (r_state == S_IDLE);
    assign dma_write_ctrl_ready = rst_n & (r_state == S_IDLE) & ~dma_read_ctrl_valid;

    assign w_rd_hs = dma_read_ctrl_valid & dma_read_ctrl_ready;
    assign w_wr_hs = dma_write_ctrl_valid & dma_write_ctrl_ready;
    assign w_hs    = w_rd_hs | w_wr_hs;

    assign w_req_index  = w_rd_hs ? dma_read_ctrl_data_index  : dma_write_ctrl_data_index;
    assign w_req_length = w_rd_hs ? dma_read_ctrl_data_length : dma_write_ctrl_data_length;
    assign w_req_size   = w_rd_hs ? dma_read_ctrl_data_size   : dma_write_ctrl_data_size;

    assign w_len_over  = (w_req_length > c_MAX_LEN);
    assign w_req_beats = w_len_over ? c_MAX_LEN[c_LEN_W-1:0] : w_req_length[c_LEN_W-1:0];
    assign w_req_zero  = (w_req_length == 32'd0);
    assign w_req_end   = {1'b0, w_req_index} + {1'b0, w_req_length};
    assign w_req_oob   = w_len_over | (w_req_end > c_MEM_WORDS);

    assign dma_read_chnl_valid = (r_cnt != 2'd0);
    assign dma_read_chnl_data  = r_buf[r_rptr];
    assign w_pop               = dma_read_chnl_valid & dma_read_chnl_ready;

    // Buffer occupancy next cycle if no new read were issued now; a new read
    // lands one cycle later, so it may only go out while this is below 2.
    assign w_occ  = {1'b0, r_cnt} + {2'b0, r_rd_pend} - {2'b0, w_pop};
    assign w_room = (w_occ < 3'd2);

    // The first read is issued in the handshake cycle straight from the
    // request index; that is what lets valid rise two cycles later.
    assign w_rd_issue = (r_state == S_IDLE) ? (w_rd_hs & ~w_req_zero)
                      : (((r_state == S_RD_FETCH) || (r_state == S_RD_STREAM))
                         && (r_left != '0) && w_room);
    assign w_wr_accept = dma_write_chnl_valid & dma_write_chnl_ready;
    assign w_a_addr    = (r_state == S_IDLE) ? w_req_index[ADDR_W-1:0] : r_addr;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt          = r_state;
        busy                 = (r_state != S_IDLE);
        dma_write_chnl_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rd_hs) begin
                    if (!w_req_zero) w_state_nxt = S_RD_FETCH;
                end else if (w_wr_hs && !w_req_zero) begin
                    w_state_nxt = S_WR_STREAM;
                end
            end
            S_RD_FETCH: w_state_nxt = S_RD_STREAM;
            S_RD_STREAM: begin
                if (w_pop && (r_out_left == c_ONE)) w_state_nxt = S_IDLE;
            end
            S_WR_STREAM: begin
                dma_write_chnl_ready = 1'b1;
                if (dma_write_chnl_valid && (r_left == c_ONE)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- burst bookkeeping and status ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_left     <= '0;
            r_out_left <= '0;
            r_rd_pend  <= 1'b0;
            size_err   <= 1'b0;
            oob_err    <= 1'b0;
            rd_bursts  <= 16'd0;
            wr_bursts  <= 16'd0;
        end else begin
            r_rd_pend <= w_rd_issue;
            if (w_hs) begin
                if (w_req_size != 3'b011) size_err <= 1'b1;
                if (w_req_oob)            oob_err  <= 1'b1;
                if (w_req_zero) begin
                    if (w_rd_hs) rd_bursts <= rd_bursts + 16'd1;
                    else         wr_bursts <= wr_bursts + 16'd1;
                end
            end
            if (w_rd_hs) begin
                r_addr     <= w_req_index[ADDR_W-1:0] + 1'b1;
                r_left     <= w_req_beats - 1'b1;
                r_out_left <= w_req_beats;
            end else if (w_wr_hs) begin
                r_addr <= w_req_index[ADDR_W-1:0];
                r_left <= w_req_beats;
            end else if (w_rd_issue || w_wr_accept) begin
                r_addr <= r_addr + 1'b1;
                r_left <= r_left - 1'b1;
            end
            if ((r_state == S_RD_STREAM) && w_pop) begin
                r_out_left <= r_out_left - 1'b1;
                if (r_out_left == c_ONE) rd_bursts <= rd_bursts + 16'd1;
            end
            if (w_wr_accept && (r_left == c_ONE)) wr_bursts <= wr_bursts + 16'd1;
        end
    end

    // ---------------- 2-entry read output buffer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 2'd0;
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
        end else begin
            if (r_rd_pend) r_wptr <= ~r_wptr;
            if (w_pop)     r_rptr <= ~r_rptr;
            r_cnt <= r_cnt + {1'b0, r_rd_pend} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (r_rd_pend) r_buf[r_wptr] <= r_a_q;
    end

    // ---------------- dual-port RAM ----------------
    // The DMA write is the later assignment, so it wins an address collision.
    always_ff @(posedge clk) begin
        if (host_we)     r_mem[host_waddr] <= host_wdata;
        if (w_wr_accept) r_mem[w_a_addr]   <= dma_write_chnl_data;
        if (w_rd_issue)  r_a_q             <= r_mem[w_a_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_rdata <= 64'd0;
        end else begin
            host_rdata <= r_mem[host_raddr];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_esp_dma_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_esp_dma_responder
//  Purpose  : Scoreboard bench for esp_dma_responder. Requests push expected
//             read beats into a queue; a monitor pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_esp_dma_responder;

    localparam int AW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              dma_read_ctrl_valid;
    logic              dma_read_ctrl_ready;
    logic [31:0]       dma_read_ctrl_data_index;
    logic [31:0]       dma_read_ctrl_data_length;
    logic [2:0]        dma_read_ctrl_data_size;
    logic [4:0]        dma_read_ctrl_data_user;
    logic              dma_read_chnl_valid;
    logic              dma_read_chnl_ready;
    logic [63:0]       dma_read_chnl_data;
    logic              dma_write_ctrl_valid;
    logic              dma_write_ctrl_ready;
    logic [31:0]       dma_write_ctrl_data_index;
    logic [31:0]       dma_write_ctrl_data_length;
    logic [2:0]        dma_write_ctrl_data_size;
    logic [4:0]        dma_write_ctrl_data_user;
    logic              dma_write_chnl_valid;
    logic              dma_write_chnl_ready;
    logic [63:0]       dma_write_chnl_data;
    logic              host_we;
    logic [AW-1:0]     host_waddr;
    logic [63:0]       host_wdata;
    logic [AW-1:0]     host_raddr;
    logic [63:0]       host_rdata;
    logic              busy;
    logic              size_err;
    logic              oob_err;
    logic [15:0]       rd_bursts;
    logic [15:0]       wr_bursts;

    esp_dma_responder #(.ADDR_W(AW), .MAX_LEN(32768)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .dma_read_ctrl_valid        (dma_read_ctrl_valid),
        .dma_read_ctrl_ready        (dma_read_ctrl_ready),
        .dma_read_ctrl_data_index   (dma_read_ctrl_data_index),
        .dma_read_ctrl_data_length  (dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size    (dma_read_ctrl_data_size),
        .dma_read_ctrl_data_user    (dma_read_ctrl_data_user),
        .dma_read_chnl_valid        (dma_read_chnl_valid),
        .dma_read_chnl_ready        (dma_read_chnl_ready),
        .dma_read_chnl_data         (dma_read_chnl_data),
        .dma_write_ctrl_valid       (dma_write_ctrl_valid),
        .dma_write_ctrl_ready       (dma_write_ctrl_ready),
        .dma_write_ctrl_data_index  (dma_write_ctrl_data_index),
        .dma_write_ctrl_data_length (dma_write_ctrl_data_length),
        .dma_write_ctrl_data_size   (dma_write_ctrl_data_size),
        .dma_write_ctrl_data_user   (dma_write_ctrl_data_user),
        .dma_write_chnl_valid       (dma_write_chnl_valid),
        .dma_write_chnl_ready       (dma_write_chnl_ready),
        .dma_write_chnl_data        (dma_write_chnl_data),
        .host_we                    (host_we),
        .host_waddr                 (host_waddr),
        .host_wdata                 (host_wdata),
        .host_raddr                 (host_raddr),
        .host_rdata                 (host_rdata),
        .busy                       (busy),
        .size_err                   (size_err),
        .oob_err                    (oob_err),
        .rd_bursts                  (rd_bursts),
        .wr_bursts                  (wr_bursts)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          beats_seen = 0;
    bit          rand_ready = 1'b0;
    logic [63:0] tb_mem [0:(1<<AW)-1];
    logic [63:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // read-channel ready: held high, or random when rand_ready is set
    initial begin
        dma_read_chnl_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dma_read_chnl_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor: compares every read beat and checks stability under backpressure
    initial begin
        bit          held;
        logic [63:0] held_data;
        held = 1'b0;
        held_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("rd_hold_valid", dma_read_chnl_valid, 1'b1);
                    check("rd_hold_data", dma_read_chnl_data, held_data);
                end
                if (dma_read_chnl_valid && dma_read_chnl_ready) begin
                    if (exp_q.size() == 0) check("rd_unexpected_beat", 1'b1, 1'b0);
                    else check("rd_beat", dma_read_chnl_data, exp_q.pop_front());
                    beats_seen++;
                    held = 1'b0;
                end else if (dma_read_chnl_valid) begin
                    held = 1'b1;
                    held_data = dma_read_chnl_data;
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic read_req(input logic [31:0] idx, input logic [31:0] len,
                            input logic [2:0] size, input bit chk_lat);
        bit ok;
        dma_read_ctrl_valid       = 1'b1;
        dma_read_ctrl_data_index  = idx;
        dma_read_ctrl_data_length = len;
        dma_read_ctrl_data_size   = size;
        ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (dma_read_ctrl_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("rd_ctrl_timeout", 1'b0, 1'b1);
        for (int k = 0; k < int'(len); k++) begin
            logic [AW-1:0] a;
            a = AW'(idx + 32'(k));
            exp_q.push_back(tb_mem[a]);
        end
        @(posedge clk);
        #1;
        dma_read_ctrl_valid = 1'b0;
        if (chk_lat) begin
            check("rd_valid_hs_plus1", dma_read_chnl_valid, 1'b0);
            @(posedge clk);
            #1;
            check("rd_valid_hs_plus2", dma_read_chnl_valid, (len != 0));
        end
    endtask

    task automatic write_burst(input logic [31:0] idx, input logic [31:0] len,
                               input logic [63:0] base, input bit collide,
                               output int rdb_at_accept);
        bit ok;
        dma_write_ctrl_valid       = 1'b1;
        dma_write_ctrl_data_index  = idx;
        dma_write_ctrl_data_length = len;
        dma_write_ctrl_data_size   = 3'b011;
        ok = 1'b0;
        rdb_at_accept = -1;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (dma_write_ctrl_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wr_ctrl_timeout", 1'b0, 1'b1);
        rdb_at_accept = int'(rd_bursts);
        @(posedge clk);
        #1;
        dma_write_ctrl_valid = 1'b0;
        for (int k = 0; k < int'(len); k++) begin
            logic [AW-1:0] a;
            a = AW'(idx + 32'(k));
            dma_write_chnl_valid = 1'b1;
            dma_write_chnl_data  = base + 64'(k);
            if (collide && k == 0) begin
                host_we    = 1'b1;
                host_waddr = a;
                host_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
            end
            ok = 1'b0;
            for (int n = 0; n < 50; n++) begin
                @(negedge clk);
                if (dma_write_chnl_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                check("wr_chnl_timeout", 1'b0, 1'b1);
                break;
            end
            tb_mem[a] = base + 64'(k);
            @(posedge clk);
            #1;
            host_we = 1'b0;
        end
        dma_write_chnl_valid = 1'b0;
        host_we = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rdb;
        int streak;
        int b0;
        bit ok;

        rst_n = 1'b0;
        dma_read_ctrl_valid = 1'b0; dma_read_ctrl_data_index = '0;
        dma_read_ctrl_data_length = '0; dma_read_ctrl_data_size = 3'b011;
        dma_read_ctrl_data_user = 5'd0;
        dma_write_ctrl_valid = 1'b0; dma_write_ctrl_data_index = '0;
        dma_write_ctrl_data_length = '0; dma_write_ctrl_data_size = 3'b011;
        dma_write_ctrl_data_user = 5'd0;
        dma_write_chnl_valid = 1'b0; dma_write_chnl_data = '0;
        host_we = 1'b0; host_waddr = '0; host_wdata = '0; host_raddr = '0;

        // reset values
        #3;
        check("rst_rd_ctrl_ready", dma_read_ctrl_ready, 1'b0);
        check("rst_wr_ctrl_ready", dma_write_ctrl_ready, 1'b0);
        check("rst_rd_chnl_valid", dma_read_chnl_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_errs", {size_err, oob_err}, 2'b00);
        check("rst_bursts", {rd_bursts, wr_bursts}, 32'd0);
        check("rst_host_rdata", host_rdata, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_rd_ctrl_ready", dma_read_ctrl_ready, 1'b1);
        check("idle_wr_ctrl_ready", dma_write_ctrl_ready, 1'b1);
        @(posedge clk);
        #1;

        // host preload
        for (int i = 0; i < 258; i++) begin
            logic [AW-1:0] a;
            a = (i < 256) ? AW'(i) : AW'(65534 + (i - 256));
            host_we = 1'b1; host_waddr = a;
            host_wdata = (i < 256) ? 64'(i) : (64'hFFFF_0000_0000_0000 | 64'(a));
            tb_mem[a] = host_wdata;
            @(posedge clk);
            #1;
        end
        host_we = 1'b0;
        host_raddr = AW'(7);
        @(posedge clk);
        #1;
        check("host_readback_7", host_rdata, 64'd7);
        host_raddr = AW'(65535);
        @(posedge clk);
        #1;
        check("host_readback_last", host_rdata, 64'hFFFF_0000_0000_FFFF);

        // 64-beat read, ready held high
        read_req(32'd0, 32'd64, 3'b011, 1'b1);
        streak = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (dma_read_chnl_valid && dma_read_chnl_ready) streak++;
        end
        check("rd64_one_beat_per_cycle", 64'(streak), 64'd64);
        wait_drain();
        check("rd64_rd_bursts", rd_bursts, 16'd1);

        // random backpressure
        rand_ready = 1'b1;
        read_req(32'd10, 32'd8, 3'b011, 1'b0);
        wait_drain();
        rand_ready = 1'b0;
        check("rd_bp_rd_bursts", rd_bursts, 16'd2);

        // write then read back, with a host collision on the first beat
        write_burst(32'd100, 32'd16, 64'hA5A5_0000_0000_0000, 1'b1, rdb);
        wait_drain();
        check("wr16_wr_bursts", wr_bursts, 16'd1);
        host_raddr = AW'(100);
        @(posedge clk);
        #1;
        check("collide_dma_wins", host_rdata, 64'hA5A5_0000_0000_0000);
        read_req(32'd100, 32'd16, 3'b011, 1'b0);
        wait_drain();
        check("rd_after_wr_rd_bursts", rd_bursts, 16'd3);

        // simultaneous read and write requests
        fork
            read_req(32'd0, 32'd8, 3'b011, 1'b0);
            write_burst(32'd200, 32'd4, 64'h1234_5678_0000_0000, 1'b0, rdb);
        join
        check("prio_wr_after_rd", 64'(rdb), 64'd4);
        wait_drain();
        check("prio_wr_bursts", wr_bursts, 16'd2);
        read_req(32'd200, 32'd4, 3'b011, 1'b0);
        wait_drain();

        // wrap-around read and size error
        check("pre_oob_err", oob_err, 1'b0);
        read_req(32'd65534, 32'd4, 3'b011, 1'b0);
        wait_drain();
        check("wrap_oob_err", oob_err, 1'b1);
        check("wrap_size_err", size_err, 1'b0);
        read_req(32'd0, 32'd1, 3'b010, 1'b0);
        wait_drain();
        check("size_err_set", size_err, 1'b1);
        check("rd_bursts_7", rd_bursts, 16'd7);

        // zero-length requests
        read_req(32'd5, 32'd0, 3'b011, 1'b1);
        check("zero_len_busy", busy, 1'b0);
        check("zero_len_rd_bursts", rd_bursts, 16'd8);
        write_burst(32'd5, 32'd0, 64'd0, 1'b0, rdb);
        @(negedge clk);
        check("zero_len_wr_bursts", wr_bursts, 16'd3);
        check("zero_len_wr_busy", busy, 1'b0);
        @(posedge clk);
        #1;

        // reset in the middle of a 32-beat read
        b0 = beats_seen;
        read_req(32'd0, 32'd32, 3'b011, 1'b0);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #2;
            if (beats_seen - b0 >= 5) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("midrst_beat5_timeout", 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", dma_read_chnl_valid, 1'b0);
        check("midrst_ctrl_ready", {dma_read_ctrl_ready, dma_write_ctrl_ready}, 2'b00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_errs", {size_err, oob_err}, 2'b00);
        check("midrst_bursts", {rd_bursts, wr_bursts}, 32'd0);
        check("midrst_host_rdata", host_rdata, 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_rd_ready", dma_read_ctrl_ready, 1'b1);
        check("postrst_valid", dma_read_chnl_valid, 1'b0);
        @(posedge clk);
        #1;
        read_req(32'd20, 32'd4, 3'b011, 1'b1);
        wait_drain();
        check("postrst_rd_bursts", rd_bursts, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
